rgb_fpga_line_fetch: RTL and testbench

RGB_FPGA_LINE_FETCH -- requirements
Module: rgb_fpga_line_fetch

---
 rtl/rgb_fpga_line_fetch.sv | 134 +++++++++++++
 tb/tb_rgb_fpga_line_fetch.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fpga_line_fetch.sv
// Line-pair fetcher: a 32x32 RGB pixel store feeds a back buffer with one top and one bottom row.
// A swap then copies the back buffer to the front buffer that drives the line PWM instances.
module rgb_fpga_line_fetch (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            wr_valid,
  output logic            wr_rdy,
  input  logic [9:0]      wr_addr,
  input  logic [23:0]     wr_data,
  input  logic            fetch_req,
  input  logic [3:0]      fetch_addr,
  output logic            fetch_done,
  input  logic            swap,
  output logic            busy,
  output logic [31:0][7:0] line_r0,
  output logic [31:0][7:0] line_g0,
  output logic [31:0][7:0] line_b0,
  output logic [31:0][7:0] line_r1,
  output logic [31:0][7:0] line_g1,
  output logic [31:0][7:0] line_b1
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} state_t;

  state_t      state_reg;
  logic [5:0]  rc_reg;
  logic [3:0]  addr_reg;
  logic        rd_valid_reg;
  logic [5:0]  rd_idx_reg;
  logic        swap_pending_reg;
  logic        fetch_done_reg;

  logic [31:0][7:0] back_r0_reg, back_g0_reg, back_b0_reg;
  logic [31:0][7:0] back_r1_reg, back_g1_reg, back_b1_reg;
  logic [31:0][7:0] front_r0_reg, front_g0_reg, front_b0_reg;
  logic [31:0][7:0] front_r1_reg, front_g1_reg, front_b1_reg;

  logic [23:0] mem [0:1023];
  logic [23:0] mem_rd_data;
  logic [9:0]  rd_addr;
  logic        wr_en;

  // Even rc reads the top row, odd rc the bottom row (addr + 16) of the same column.
  assign rd_addr = {rc_reg[0], addr_reg, rc_reg[5:1]};
  assign wr_rdy  = (state_reg == IDLE);
  assign busy    = (state_reg != IDLE);
  assign wr_en   = wr_valid && wr_rdy;

  // Single-port store: writes only happen in IDLE, reads only in FETCH.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end else if (enable && state_reg == FETCH) begin
      mem_rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      rc_reg           <= '0;
      addr_reg         <= '0;
      rd_valid_reg     <= 1'b0;
      rd_idx_reg       <= '0;
      swap_pending_reg <= 1'b0;
      fetch_done_reg   <= 1'b0;
      back_r0_reg  <= '0; back_g0_reg  <= '0; back_b0_reg  <= '0;
      back_r1_reg  <= '0; back_g1_reg  <= '0; back_b1_reg  <= '0;
      front_r0_reg <= '0; front_g0_reg <= '0; front_b0_reg <= '0;
      front_r1_reg <= '0; front_g1_reg <= '0; front_b1_reg <= '0;
    end else begin
      fetch_done_reg <= 1'b0;
      if (enable) begin
        case (state_reg)
          IDLE: begin
            if (fetch_req) begin
              addr_reg  <= fetch_addr;
              rc_reg    <= '0;
              state_reg <= FETCH;
            end
          end
          FETCH: begin
            rc_reg <= rc_reg + 6'd1;
            if (rc_reg == 6'd63) state_reg <= CAPTURE;
          end
          CAPTURE: begin
            state_reg      <= IDLE;
            fetch_done_reg <= 1'b1;
          end
          default: state_reg <= IDLE;
        endcase

        rd_valid_reg <= (state_reg == FETCH);
        rd_idx_reg   <= rc_reg;
        if (rd_valid_reg) begin
          if (rd_idx_reg[0]) begin
            back_r1_reg[rd_idx_reg[5:1]] <= mem_rd_data[23:16];
            back_g1_reg[rd_idx_reg[5:1]] <= mem_rd_data[15:8];
            back_b1_reg[rd_idx_reg[5:1]] <= mem_rd_data[7:0];
          end else begin
            back_r0_reg[rd_idx_reg[5:1]] <= mem_rd_data[23:16];
            back_g0_reg[rd_idx_reg[5:1]] <= mem_rd_data[15:8];
            back_b0_reg[rd_idx_reg[5:1]] <= mem_rd_data[7:0];
          end
        end

        // A swap seen while busy is deferred to the first idle edge, which is the fetch_done cycle.
        if (state_reg == IDLE) begin
          if (swap || swap_pending_reg) begin
            front_r0_reg     <= back_r0_reg;
            front_g0_reg     <= back_g0_reg;
            front_b0_reg     <= back_b0_reg;
            front_r1_reg     <= back_r1_reg;
            front_g1_reg     <= back_g1_reg;
            front_b1_reg     <= back_b1_reg;
            swap_pending_reg <= 1'b0;
          end
        end else if (swap) begin
          swap_pending_reg <= 1'b1;
        end
      end
    end
  end

  assign fetch_done = fetch_done_reg;
  assign line_r0    = front_r0_reg;
  assign line_g0    = front_g0_reg;
  assign line_b0    = front_b0_reg;
  assign line_r1    = front_r1_reg;
  assign line_g1    = front_g1_reg;
  assign line_b1    = front_b1_reg;

endmodule

// File: tb/tb_rgb_fpga_line_fetch.sv
// Bench for rgb_fpga_line_fetch: scenario tasks compared against a pixel-array model of the store
// and of the front buffer contents.
module tb_rgb_fpga_line_fetch;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            wr_valid;
  logic            wr_rdy;
  logic [9:0]      wr_addr;
  logic [23:0]     wr_data;
  logic            fetch_req;
  logic [3:0]      fetch_addr;
  logic            fetch_done;
  logic            swap;
  logic            busy;
  logic [31:0][7:0] line_r0, line_g0, line_b0, line_r1, line_g1, line_b1;

  rgb_fpga_line_fetch dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wr_valid(wr_valid), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
    .swap(swap), .busy(busy),
    .line_r0(line_r0), .line_g0(line_g0), .line_b0(line_b0),
    .line_r1(line_r1), .line_g1(line_g1), .line_b1(line_b1)
  );

  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [23:0]   model_mem [0:1023];
  logic [1535:0] model_front;
  logic [1535:0] dut_lines;
  assign dut_lines = {line_r0, line_g0, line_b0, line_r1, line_g1, line_b1};

  // Expected line set for scan address a: top row a, bottom row a+16.
  function automatic logic [1535:0] expect_lines(input int a);
    logic [1535:0] v;
    logic [23:0]   t, b;
    v = '0;
    for (int c = 0; c < 32; c++) begin
      t = model_mem[a * 32 + c];
      b = model_mem[(a + 16) * 32 + c];
      v[5*256 + c*8 +: 8] = t[23:16];
      v[4*256 + c*8 +: 8] = t[15:8];
      v[3*256 + c*8 +: 8] = t[7:0];
      v[2*256 + c*8 +: 8] = b[23:16];
      v[1*256 + c*8 +: 8] = b[15:8];
      v[c*8 +: 8]         = b[7:0];
    end
    return v;
  endfunction

  function automatic string diff_str(input logic [1535:0] act, input logic [1535:0] exp_v);
    for (int i = 0; i < 192; i++)
      if (act[i*8 +: 8] !== exp_v[i*8 +: 8])
        return $sformatf("byte %0d got %02h exp %02h", i, act[i*8 +: 8], exp_v[i*8 +: 8]);
    return "no diff";
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [23:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic start_fetch(input logic [3:0] a);
    fetch_addr = a; fetch_req = 1'b1;
    tick();
    fetch_req  = 1'b0;
    fetch_addr = 4'($urandom);
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (fetch_done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    check_cnt++;
    if (fetch_done !== 1'b0) $display("FAIL reset_done got %b exp 0", fetch_done); else pass_cnt++;
    check_cnt++;
    if (dut_lines !== '0) $display("FAIL reset_lines %s", diff_str(dut_lines, '0)); else pass_cnt++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_cnt++;
    if (wr_rdy !== 1'b1) $display("FAIL reset_wr_rdy got %b exp 1", wr_rdy); else pass_cnt++;
    model_front = '0;
    $display("test_reset done");
  endtask

  task automatic fill_memory();
    for (int i = 0; i < 1024; i++) do_write(10'(i), 24'($urandom));
    $display("fill_memory: 1024 pixels written");
  endtask

  task automatic test_directed();
    int lat;
    do_write(10'd0, 24'hFF8001);
    // Write row 16 col 31 in the same cycle as the fetch request.
    wr_valid = 1'b1; wr_addr = {5'd16, 5'd31}; wr_data = 24'h0A0B0C;
    fetch_addr = 4'd0; fetch_req = 1'b1;
    tick();
    wr_valid = 1'b0; fetch_req = 1'b0;
    model_mem[{5'd16, 5'd31}] = 24'h0A0B0C;
    wait_done(200, lat);
    check_cnt++;
    if (lat !== 65) $display("FAIL directed_latency got %0d exp 65", lat); else pass_cnt++;
    do_swap();
    model_front = expect_lines(0);
    check_cnt++;
    if ({line_r0[0], line_g0[0], line_b0[0]} !== 24'hFF8001)
      $display("FAIL directed_top got %02h%02h%02h exp FF8001", line_r0[0], line_g0[0], line_b0[0]);
    else pass_cnt++;
    check_cnt++;
    if ({line_r1[31], line_g1[31], line_b1[31]} !== 24'h0A0B0C)
      $display("FAIL directed_bottom got %02h%02h%02h exp 0A0B0C", line_r1[31], line_g1[31], line_b1[31]);
    else pass_cnt++;
    check_cnt++;
    if (dut_lines !== model_front) $display("FAIL directed_lines %s", diff_str(dut_lines, model_front));
    else pass_cnt++;
    $display("test_directed: addr 0 latency %0d", lat);
  endtask

  task automatic test_latency();
    int lat;
    logic [3:0] a;
    a = 4'($urandom);
    start_fetch(a);
    check_cnt++;
    if (busy !== 1'b1 || wr_rdy !== 1'b0)
      $display("FAIL latency_busy got busy=%b wr_rdy=%b exp busy=1 wr_rdy=0", busy, wr_rdy);
    else pass_cnt++;
    wait_done(200, lat);
    check_cnt++;
    if (lat !== 65) $display("FAIL latency_done got %0d exp 65", lat); else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL latency_busy_end got %b exp 0", busy); else pass_cnt++;
    tick();
    check_cnt++;
    if (fetch_done !== 1'b0) $display("FAIL latency_pulse_width got %b exp 0", fetch_done); else pass_cnt++;
    check_cnt++;
    if (dut_lines !== model_front) $display("FAIL latency_no_swap %s", diff_str(dut_lines, model_front));
    else pass_cnt++;
    $display("test_latency: addr %0d latency %0d", a, lat);
  endtask

  task automatic test_swap_pending();
    int lat, changed;
    logic [3:0] a, b;
    a = 4'($urandom);
    b = a + 4'd7;
    do_write({1'b0, a, 5'd3}, 24'($urandom));
    start_fetch(a);
    lat = -1; changed = 0;
    for (int k = 1; k <= 200; k++) begin
      swap = (k == 10);
      tick();
      if (dut_lines !== model_front) changed++;
      if (fetch_done === 1'b1) begin
        lat = k;
        break;
      end
    end
    swap = 1'b0;
    check_cnt++;
    if (changed !== 0) $display("FAIL pending_early_copy got %0d changed cycles exp 0", changed);
    else pass_cnt++;
    check_cnt++;
    if (lat !== 65) $display("FAIL pending_latency got %0d exp 65", lat); else pass_cnt++;
    tick();
    model_front = expect_lines(a);
    check_cnt++;
    if (dut_lines !== model_front) $display("FAIL pending_copy %s", diff_str(dut_lines, model_front));
    else pass_cnt++;
    // A second fetch without swap must not touch the front buffer.
    start_fetch(b);
    wait_done(200, lat);
    tick(); tick();
    check_cnt++;
    if (dut_lines !== model_front) $display("FAIL pending_single_copy %s", diff_str(dut_lines, model_front));
    else pass_cnt++;
    $display("test_swap_pending: addr %0d then %0d", a, b);
  endtask

  task automatic test_back_to_back();
    int lat, stall_bad;
    logic [3:0]    a;
    logic [9:0]    wa;
    logic [23:0]   wd;
    logic [1535:0] exp_old;
    a  = 4'($urandom);
    wa = {1'b0, a, 5'($urandom)};
    wd = 24'($urandom);
    exp_old = expect_lines(a);
    start_fetch(a);
    wr_valid = 1'b1; wr_addr = wa; wr_data = wd;
    lat = -1; stall_bad = 0;
    for (int k = 1; k <= 200; k++) begin
      fetch_req  = (k == 5);
      fetch_addr = a + 4'd3;
      tick();
      if (busy && wr_rdy) stall_bad++;
      if (fetch_done === 1'b1) begin
        lat = k;
        break;
      end
    end
    fetch_req = 1'b0;
    check_cnt++;
    if (lat !== 65) $display("FAIL b2b_latency got %0d exp 65", lat); else pass_cnt++;
    check_cnt++;
    if (stall_bad !== 0) $display("FAIL b2b_wr_rdy_stall got %0d bad cycles exp 0", stall_bad); else pass_cnt++;
    check_cnt++;
    if (wr_rdy !== 1'b1) $display("FAIL b2b_wr_rdy_idle got %b exp 1", wr_rdy); else pass_cnt++;
    tick();
    wr_valid = 1'b0;
    model_mem[wa] = wd;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL b2b_no_restart got busy=%b exp 0", busy); else pass_cnt++;
    do_swap();
    model_front = exp_old;
    check_cnt++;
    if (dut_lines !== model_front) $display("FAIL b2b_old_data %s", diff_str(dut_lines, model_front));
    else pass_cnt++;
    start_fetch(a);
    wait_done(200, lat);
    do_swap();
    model_front = expect_lines(a);
    check_cnt++;
    if (dut_lines !== model_front) $display("FAIL b2b_write_landed %s", diff_str(dut_lines, model_front));
    else pass_cnt++;
    $display("test_back_to_back: addr %0d write %03h=%06h", a, wa, wd);
  endtask

  task automatic test_enable_stall();
    int lat;
    logic [3:0] a;
    a = 4'($urandom);
    start_fetch(a);
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      enable = !(k >= 15 && k < 35);
      tick();
      if (fetch_done === 1'b1) begin
        lat = k;
        break;
      end
    end
    enable = 1'b1;
    check_cnt++;
    if (lat !== 85) $display("FAIL stall_latency got %0d exp 85", lat); else pass_cnt++;
    do_swap();
    model_front = expect_lines(a);
    check_cnt++;
    if (dut_lines !== model_front) $display("FAIL stall_data %s", diff_str(dut_lines, model_front));
    else pass_cnt++;
    $display("test_enable_stall: addr %0d latency %0d", a, lat);
  endtask

  task automatic test_reset_mid();
    int lat, done_seen;
    start_fetch(4'($urandom));
    for (int k = 0; k < 30; k++) tick();
    rst_n = 1'b0;
    #1;
    model_front = '0;
    check_cnt++;
    if (dut_lines !== '0) $display("FAIL midreset_lines %s", diff_str(dut_lines, '0)); else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL midreset_busy got %b exp 0", busy); else pass_cnt++;
    tick(); tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (fetch_done === 1'b1) done_seen++;
    end
    check_cnt++;
    if (done_seen !== 0) $display("FAIL midreset_no_done got %0d pulses exp 0", done_seen); else pass_cnt++;
    start_fetch(4'd15);
    wait_done(200, lat);
    do_swap();
    model_front = expect_lines(15);
    check_cnt++;
    if (dut_lines !== model_front) $display("FAIL midreset_refetch %s", diff_str(dut_lines, model_front));
    else pass_cnt++;
    $display("test_reset_mid: refetch addr 15 latency %0d", lat);
  endtask

  task automatic test_random();
    int lat, swap_at;
    logic [3:0] a;
    bit early;
    for (int it = 0; it < 8; it++) begin
      a = 4'($urandom);
      for (int w = 0; w < 3; w++)
        do_write({1'($urandom), a, 5'($urandom)}, 24'($urandom));
      early   = 1'($urandom);
      swap_at = early ? int'($urandom_range(2, 60)) : -1;
      start_fetch(a);
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
        swap = (k == swap_at);
        tick();
        if (fetch_done === 1'b1) begin
          lat = k;
          break;
        end
      end
      check_cnt++;
      if (lat !== 65) $display("FAIL random_latency it %0d got %0d exp 65", it, lat); else pass_cnt++;
      // Late case: swap coincides with the fetch_done cycle.
      swap = !early;
      tick();
      swap = 1'b0;
      model_front = expect_lines(a);
      check_cnt++;
      if (dut_lines !== model_front) $display("FAIL random_lines it %0d %s", it, diff_str(dut_lines, model_front));
      else pass_cnt++;
      $display("test_random: it %0d addr %0d early_swap %0d latency %0d", it, a, early, lat);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    fetch_req = 1'b0; fetch_addr = '0; swap = 1'b0;
    model_front = '0;
    test_reset();
    fill_memory();
    test_directed();
    test_latency();
    test_swap_pending();
    test_back_to_back();
    test_enable_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
